// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - board geometry, cell codes, coordinate widths and writer FSM encoding
package snake_pkg;

  // Board geometry
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int DEPTH = COLS * ROWS;

  // Coordinate widths: 7 bits covers 0..79, 5 bits covers 0..29
  localparam int X_W = 7;
  localparam int Y_W = 5;

  // Cell codes stored in the board RAM
  localparam logic [2:0] CELL_EMPTY = 3'd0;
  localparam logic [2:0] CELL_FOOD  = 3'd2;
  localparam logic [2:0] CELL_BODY  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RD_HEAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WR_HEAD = 3'd4,
    ST_WR_TAIL = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // True when (x, y) lies inside a board of num_cols x num_rows cells
  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int num_cols, input int num_rows);
    return (int'(x) < num_cols) && (int'(y) < num_rows);
  endfunction

endpackage

// File: rtl/cell_addr.sv
// rtl/cell_addr.sv - combinational (x, y) to board RAM address mapping
// Ports:
//   x_i    column coordinate
//   y_i    row coordinate
//   addr_o y*NUM_COLS + x, computed at full precision then truncated to ADDR_WIDTH
module cell_addr import snake_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_COLS   = COLS
) (
  input  logic [X_W-1:0]        x_i,
  input  logic [Y_W-1:0]        y_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  // 32-bit arithmetic is wide enough for any realistic board; the cast truncates
  assign addr_o = ADDR_WIDTH'(int'(y_i) * NUM_COLS + int'(x_i));

endmodule

// File: rtl/snake_board_writer.sv
// rtl/snake_board_writer.sv - write-side sequencer for the snake board RAM
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_clear, i_step         commands (clear wins when both are high)
//   i_head_x/y, i_tail_x/y  step coordinates, latched when a step is accepted
//   o_busy, o_done          command in progress / one-cycle completion pulse
//   o_collision, o_ate      result flags of the last step
//   o_addr, o_write, o_data registered RAM request
//   i_rdata                 RAM registered read data
module snake_board_writer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 3,
  parameter int COLS       = snake_pkg::COLS,
  parameter int ROWS       = snake_pkg::ROWS,
  parameter logic [DATA_WIDTH-1:0] CELL_EMPTY = DATA_WIDTH'(snake_pkg::CELL_EMPTY),
  parameter logic [DATA_WIDTH-1:0] CELL_FOOD  = DATA_WIDTH'(snake_pkg::CELL_FOOD),
  parameter logic [DATA_WIDTH-1:0] CELL_BODY  = DATA_WIDTH'(snake_pkg::CELL_BODY)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic                        i_step,
  input  logic [snake_pkg::X_W-1:0]   i_head_x,
  input  logic [snake_pkg::Y_W-1:0]   i_head_y,
  input  logic [snake_pkg::X_W-1:0]   i_tail_x,
  input  logic [snake_pkg::Y_W-1:0]   i_tail_y,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_collision,
  output logic                        o_ate,
  output logic [ADDR_WIDTH-1:0]       o_addr,
  output logic                        o_write,
  output logic [DATA_WIDTH-1:0]       o_data,
  input  logic [DATA_WIDTH-1:0]       i_rdata
);

  import snake_pkg::*;

  localparam int DEPTH = COLS * ROWS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [X_W-1:0]          head_x_q, head_x_d;
  logic [Y_W-1:0]          head_y_q, head_y_d;
  logic [X_W-1:0]          tail_x_q, tail_x_d;
  logic [Y_W-1:0]          tail_y_q, tail_y_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    coll_q, coll_d;
  logic                    ate_q, ate_d;

  logic [X_W-1:0]          head_x_sel;
  logic [Y_W-1:0]          head_y_sel;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [ADDR_WIDTH-1:0]   tail_addr;
  logic                    head_in_board;

  // The read address must already be on o_addr during RD_HEAD, so it is
  // registered on the accepting edge straight from the inputs; afterwards the
  // latched copy is used.
  assign head_x_sel = (state_q == ST_IDLE) ? i_head_x : head_x_q;
  assign head_y_sel = (state_q == ST_IDLE) ? i_head_y : head_y_q;

  assign head_in_board = in_bounds(i_head_x, i_head_y, COLS, ROWS);

  cell_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COLS   (COLS)
  ) u_head_addr (
    .x_i    (head_x_sel),
    .y_i    (head_y_sel),
    .addr_o (head_addr)
  );

  cell_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_COLS   (COLS)
  ) u_tail_addr (
    .x_i    (tail_x_q),
    .y_i    (tail_y_q),
    .addr_o (tail_addr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      head_x_q <= '0;
      head_y_q <= '0;
      tail_x_q <= '0;
      tail_y_q <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      data_q   <= '0;
      coll_q   <= 1'b0;
      ate_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      tail_x_q <= tail_x_d;
      tail_y_q <= tail_y_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      data_q   <= data_d;
      coll_q   <= coll_d;
      ate_q    <= ate_d;
    end
  end

  // RAM request registers are loaded with the values the next state needs,
  // so each state sees its own address/write/data during its cycle.
  always_comb begin
    state_d  = state_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    tail_x_d = tail_x_q;
    tail_y_d = tail_y_q;
    addr_d   = addr_q;
    write_d  = 1'b0;
    data_d   = data_q;
    coll_d   = coll_q;
    ate_d    = ate_q;

    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
          write_d = 1'b1;
          data_d  = CELL_EMPTY;
        end else if (i_step) begin
          head_x_d = i_head_x;
          head_y_d = i_head_y;
          tail_x_d = i_tail_x;
          tail_y_d = i_tail_y;
          coll_d   = 1'b0;
          ate_d    = 1'b0;
          if (!head_in_board) begin
            coll_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD_HEAD;
            addr_d  = head_addr;
          end
        end
      end

      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          write_d = 1'b1;
        end
      end

      // Read data for the head cell arrives in the following cycle
      ST_RD_HEAD: state_d = ST_CHECK;

      ST_CHECK: begin
        if (i_rdata == CELL_BODY) begin
          coll_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (i_rdata == CELL_FOOD) begin
            ate_d = 1'b1;
          end
          state_d = ST_WR_HEAD;
          addr_d  = head_addr;
          write_d = 1'b1;
          data_d  = CELL_BODY;
        end
      end

      ST_WR_HEAD: begin
        // Eating keeps the tail in place so the snake grows by one
        if (ate_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR_TAIL;
          addr_d  = tail_addr;
          write_d = 1'b1;
          data_d  = CELL_EMPTY;
        end
      end

      ST_WR_TAIL: state_d = ST_DONE;

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_collision = coll_q;
  assign o_ate       = ate_q;
  assign o_addr      = addr_q;
  assign o_write     = write_q;
  assign o_data      = data_q;

endmodule

// File: tb/tb_snake_board_writer.sv
// tb/tb_snake_board_writer.sv - scoreboard bench for snake_board_writer with a behavioural board model
module tb_snake_board_writer;

  localparam int AW    = 12;
  localparam int DW    = 3;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int DEPTH = COLS * ROWS;

  localparam logic [1:0] K_RD   = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_BAD  = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          coll;
    logic          ate;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          step = 1'b0;
  logic [6:0]    hx = '0;
  logic [4:0]    hy = '0;
  logic [6:0]    tx = '0;
  logic [4:0]    ty = '0;
  logic          busy, done, coll, ate, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  int checks = 0;
  int errors = 0;

  ev_t        exp_q[$];
  logic [2:0] board [0:DEPTH-1];
  logic [2:0] ram   [0:(1<<AW)-1];
  bit         exp_coll = 1'b0;
  bit         exp_ate  = 1'b0;

  always #5 clk = ~clk;

  snake_board_writer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_step      (step),
    .i_head_x    (hx),
    .i_head_y    (hy),
    .i_tail_x    (tx),
    .i_tail_y    (ty),
    .o_busy      (busy),
    .o_done      (done),
    .o_collision (coll),
    .o_ate       (ate),
    .o_addr      (addr),
    .o_write     (wr),
    .o_data      (wdata),
    .i_rdata     (rdata)
  );

  // Single-port RAM with registered read; read data is held during writes
  always @(posedge clk) begin
    if (wr) ram[addr] <= wdata;
    else    rdata     <= ram[addr];
  end

  function automatic ev_t mk(input logic [1:0] k, input int a, input int d,
                             input logic c, input logic at);
    ev_t e;
    e.kind = k;
    e.addr = AW'(a);
    e.data = DW'(d);
    e.coll = c;
    e.ate  = at;
    return e;
  endfunction

  // Monitor: every busy cycle produces exactly one event, so event order also pins latency
  always @(negedge clk) begin
    ev_t got;
    ev_t e;
    if (rst_n && (busy || done)) begin
      if (done)    got = mk(busy ? K_DONE : K_BAD, 0, 0, coll, ate);
      else if (wr) got = mk(K_WR, int'(addr), int'(wdata), 1'b0, 1'b0);
      else         got = mk(K_RD, int'(addr), 0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got kind=%0d addr=%0d data=%0d coll=%0b ate=%0b, required no event",
                 got.kind, got.addr, got.data, got.coll, got.ate);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL ram_event got kind=%0d addr=%0d data=%0d coll=%0b ate=%0b, required kind=%0d addr=%0d data=%0d coll=%0b ate=%0b",
                   got.kind, got.addr, got.data, got.coll, got.ate,
                   e.kind, e.addr, e.data, e.coll, e.ate);
        end
      end
    end
  end

  // Reference model of one step, straight from the game rules
  task automatic predict_step(input int x, input int y, input int t_x, input int t_y);
    int h;
    int t;
    exp_coll = 1'b0;
    exp_ate  = 1'b0;
    if (x >= COLS || y >= ROWS) begin
      exp_coll = 1'b1;
      exp_q.push_back(mk(K_DONE, 0, 0, 1'b1, 1'b0));
      return;
    end
    h = y * COLS + x;
    t = t_y * COLS + t_x;
    exp_q.push_back(mk(K_RD, h, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(K_RD, h, 0, 1'b0, 1'b0));
    if (board[h] == 3'd4) begin
      exp_coll = 1'b1;
      exp_q.push_back(mk(K_DONE, 0, 0, 1'b1, 1'b0));
      return;
    end
    if (board[h] == 3'd2) exp_ate = 1'b1;
    board[h] = 3'd4;
    exp_q.push_back(mk(K_WR, h, 4, 1'b0, 1'b0));
    if (!exp_ate) begin
      board[t] = 3'd0;
      exp_q.push_back(mk(K_WR, t, 0, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(K_DONE, 0, 0, 1'b0, exp_ate));
  endtask

  task automatic predict_clear();
    for (int a = 0; a < DEPTH; a++) begin
      board[a] = 3'd0;
      exp_q.push_back(mk(K_WR, a, 0, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(K_DONE, 0, 0, exp_coll, exp_ate));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_before got=%b required=0", name, busy);
    end
  endtask

  task automatic do_step(input int x, input int y, input int t_x, input int t_y);
    @(negedge clk);
    check_idle("step");
    hx = 7'(x);
    hy = 5'(y);
    tx = 7'(t_x);
    ty = 5'(t_y);
    step = 1'b1;
    predict_step(x, y, t_x, t_y);
    @(posedge clk);
    #1 step = 1'b0;
    wait_drain("step");
  endtask

  task automatic start_clear(input bit with_step);
    @(negedge clk);
    check_idle("clear");
    clear = 1'b1;
    if (with_step) begin
      hx = 7'd1;
      hy = 5'd1;
      tx = 7'd2;
      ty = 5'd1;
      step = 1'b1;
    end
    predict_clear();
    @(posedge clk);
    #1;
    clear = 1'b0;
    step  = 1'b0;
  endtask

  task automatic poke(input int a, input logic [2:0] v);
    ram[a]   = v;
    board[a] = v;
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_o_write"},     int'(wr),    0);
    chk({name, "_o_addr"},      int'(addr),  0);
    chk({name, "_o_data"},      int'(wdata), 0);
    chk({name, "_o_busy"},      int'(busy),  0);
    chk({name, "_o_done"},      int'(done),  0);
    chk({name, "_o_collision"}, int'(coll),  0);
    chk({name, "_o_ate"},       int'(ate),   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, t_x, t_y, a, bad;
    for (int i = 0; i < (1 << AW); i++) ram[i] = (i < DEPTH) ? 3'd5 : 3'd7;
    for (int i = 0; i < DEPTH; i++) board[i] = 3'd5;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    #1 rst_n = 1'b1;

    // Full clear
    start_clear(1'b0);
    wait_drain("clear");

    // Directed steps: empty, food, body, wall
    do_step(10, 5, 6, 5);
    chk("normal_collision", int'(coll), 0);
    chk("normal_ate", int'(ate), 0);
    poke(410, 3'd2);
    poke(406, 3'd4);
    do_step(10, 5, 6, 5);
    chk("food_ate", int'(ate), 1);
    do_step(10, 5, 6, 5);
    chk("body_collision", int'(coll), 1);
    do_step(80, 0, 6, 5);
    chk("wall_collision", int'(coll), 1);

    // Random steps in a small region so food and body hits are frequent
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = int'($urandom_range(0, 3)) * COLS + int'($urandom_range(0, 11));
        if (board[a] == 3'd0) poke(a, 3'd2);
      end
      x   = int'($urandom_range(0, 11));
      y   = int'($urandom_range(0, 3));
      t_x = int'($urandom_range(0, 11));
      t_y = int'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: x = int'($urandom_range(80, 127));
        1: y = int'($urandom_range(30, 31));
        default: ;
      endcase
      do_step(x, y, t_x, t_y);
      chk("rand_collision_flag", int'(coll), int'(exp_coll));
      chk("rand_ate_flag", int'(ate), int'(exp_ate));
    end

    // Clear and step together: clear wins, flags untouched
    start_clear(1'b1);
    wait_drain("clear_step");

    // Reset in the middle of a clear
    start_clear(1'b0);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_coll = 1'b0;
    exp_ate  = 1'b0;
    #1 check_reset("mid_clear");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Normal step after the aborted clear
    do_step(3, 2, 4, 2);
    chk("post_reset_collision", int'(coll), 0);
    chk("post_reset_ate", int'(ate), 0);

    // Board contents against the model; address DEPTH is never touched
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== board[i]) bad++;
    chk("board_contents_mismatches", bad, 0);
    chk("addr_depth_untouched", int'(ram[DEPTH]), 7);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
